// File: rtl/hex_scroll_display.sv
// rtl/hex_scroll_display.sv - multi-digit 7-segment message buffer with edit and scroll modes
// Characters load from the switches into a circular buffer; the window scrolls one step per TICK_DIV cycles.
module hex_scroll_display #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 16,
  parameter int TICK_DIV   = 25_000_000
) (
  input  logic                    CLOCK_50,
  input  logic                    Resetn,
  input  logic [9:0]              SW,
  input  logic [1:0]              KEY,
  output logic [9:0]              LEDR,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic {EDIT, SCROLL} state_t;

  state_t          state;
  logic [1:0]      key_s1, key_s2, key_d;
  logic [1:0]      sw_s1, sw_s2;
  logic [2:0]      msg [MSG_LEN];
  logic [AW-1:0]   wr_ptr;
  logic [5:0]      len;
  logic [5:0]      win;
  logic [CW-1:0]   cnt;
  logic            load_p, clear_p, scroll_en, dir;
  logic            unused_sw;

  assign load_p    = key_d[0] & ~key_s2[0];
  assign clear_p   = key_d[1] & ~key_s2[1];
  assign scroll_en = sw_s2[1];
  assign dir       = sw_s2[0];
  assign unused_sw = ^SW[7:3];

  function automatic logic [6:0] glyph(input logic [2:0] e);
    logic [6:0] g;
    g = 7'h7F;
    if (!e[2]) begin
      case (e[1:0])
        2'b00:   g = 7'h41;
        2'b01:   g = 7'h7A;
        2'b10:   g = 7'h25;
        default: g = 7'h30;
      endcase
    end
    return g;
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      // keys reset to the released level so leaving reset never fakes a press
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      key_d  <= 2'b11;
      sw_s1  <= 2'b00;
      sw_s2  <= 2'b00;
      state  <= EDIT;
      wr_ptr <= '0;
      len    <= '0;
      win    <= '0;
      cnt    <= '0;
      for (int i = 0; i < MSG_LEN; i++) msg[i] <= 3'b100;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      key_d  <= key_s2;
      sw_s1  <= SW[9:8];
      sw_s2  <= sw_s1;
      case (state)
        EDIT: begin
          if (clear_p) begin
            len    <= '0;
            wr_ptr <= '0;
          end else if (load_p) begin
            msg[wr_ptr] <= SW[2:0];
            wr_ptr      <= (wr_ptr == AW'(MSG_LEN - 1)) ? '0 : wr_ptr + 1'b1;
            if (len != 6'(MSG_LEN)) len <= len + 1'b1;
          end
          if (scroll_en && len != 6'd0) begin
            state <= SCROLL;
            win   <= '0;
            cnt   <= '0;
          end
        end
        default: begin
          if (!scroll_en) begin
            state <= EDIT;
            win   <= '0;
            cnt   <= '0;
          end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt <= '0;
            if (!dir) win <= (win == len - 1'b1) ? 6'd0 : win + 1'b1;
            else      win <= (win == 6'd0) ? len - 1'b1 : win - 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    HEX = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      logic [2:0]    ent;
      logic [AW-1:0] phys;
      int            li;
      ent  = 3'b100;
      phys = '0;
      li   = 0;
      if (state == EDIT) begin
        if (k < int'(len)) begin
          phys = AW'((int'(wr_ptr) + MSG_LEN - 1 - k) % MSG_LEN);
          ent  = msg[phys];
        end
      end else if (len != 6'd0) begin
        // leftmost digit carries the window start; short messages repeat
        li   = (int'(win) + NUM_DIGITS - 1 - k) % int'(len);
        phys = AW'((int'(wr_ptr) + MSG_LEN - int'(len) + li) % MSG_LEN);
        ent  = msg[phys];
      end
      HEX[7*k +: 7] = glyph(ent);
    end
  end

  assign LEDR = {len, state == SCROLL, SW[2:0]};

endmodule

// File: tb/tb_hex_scroll_display.sv
// tb/tb_hex_scroll_display.sv - self-checking bench for hex_scroll_display
// A queue-based message model predicts HEX/LEDR for directed and random load/scroll sequences.
module tb_hex_scroll_display;

  localparam int ND = 4;
  localparam int ML = 8;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  sw;
  logic [1:0]  key;
  logic [9:0]  ledr;
  logic [27:0] hex;

  int passed = 0;
  int total  = 0;

  logic [2:0] q[$];
  bit         m_scroll;
  bit         m_dir;
  int         win;
  int         sc;

  always #5 clk = ~clk;

  hex_scroll_display #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
    .CLOCK_50(clk),
    .Resetn  (resetn),
    .SW      (sw),
    .KEY     (key),
    .LEDR    (ledr),
    .HEX     (hex)
  );

  function automatic logic [6:0] glyph_of(input logic [2:0] e);
    if (e[2]) return 7'h7F;
    case (e[1:0])
      2'b00:   return 7'h41;
      2'b01:   return 7'h7A;
      2'b10:   return 7'h25;
      default: return 7'h30;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex();
    logic [27:0] h;
    int n;
    n = q.size();
    h = '1;
    for (int d = 0; d < ND; d++) begin
      if (!m_scroll) begin
        if (d < n) h[7*d +: 7] = glyph_of(q[n-1-d]);
      end else begin
        h[7*d +: 7] = glyph_of(q[(win + (ND-1-d)) % n]);
      end
    end
    return h;
  endfunction

  function automatic logic [9:0] exp_led();
    return {6'(q.size()), m_scroll, sw[2:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, " hex"}, 32'(hex), 32'(exp_hex()));
    check({tag, " ledr"}, 32'(ledr), 32'(exp_led()));
  endtask

  task automatic cyc();
    int n;
    @(posedge clk);
    if (m_scroll) begin
      n = q.size();
      sc++;
      if (sc == TD) begin
        sc  = 0;
        win = m_dir ? (win + n - 1) % n : (win + 1) % n;
      end
    end
    @(negedge clk);
  endtask

  task automatic press(input bit ld, input bit cl, input logic [2:0] v, input int hold);
    sw[2:0] = v;
    sw[7:3] = 5'($urandom);
    key = {~cl, ~ld};
    cyc();
    cyc();
    check_all("pre_write");
    cyc();
    if (!m_scroll) begin
      if (cl) q.delete();
      else if (ld) begin
        q.push_back(v);
        if (q.size() > ML) void'(q.pop_front());
      end
    end
    check_all("post_write");
    repeat (hold) cyc();
    key = 2'b11;
    repeat (3) cyc();
    check_all("after_release");
  endtask

  task automatic set_en(input bit v);
    sw[9] = v;
    cyc();
    cyc();
    check("en_sync led3", 32'(ledr[3]), 32'(m_scroll));
    @(posedge clk);
    if (v) begin
      if (q.size() > 0) begin
        m_scroll = 1'b1;
        sc = 0;
        win = 0;
      end
    end else begin
      m_scroll = 1'b0;
    end
    @(negedge clk);
    check_all("en_edge2");
  endtask

  task automatic run_scroll(input int n);
    repeat (n) begin
      cyc();
      check("scroll hex", 32'(hex), 32'(exp_hex()));
    end
  endtask

  initial begin
    resetn = 1'b0;
    sw = '0;
    key = 2'b11;
    m_scroll = 1'b0;
    m_dir = 1'b0;
    win = 0;
    sc = 0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset hex", 32'(hex), 32'h0FFF_FFFF);
    check("reset ledr", 32'(ledr), 32'h0);
    resetn = 1'b1;
    cyc();
    check_all("post_reset");

    for (int c = 0; c < 4; c++) press(1'b1, 1'b0, 3'(c), 0);
    check("four codes", 32'(hex), 32'({7'h41, 7'h7A, 7'h25, 7'h30}));
    check("four len", 32'(ledr[9:4]), 32'd4);

    sw[8] = 1'b0;
    m_dir = 1'b0;
    set_en(1'b1);
    run_scroll(TD);
    check("first step", 32'(hex), 32'({7'h7A, 7'h25, 7'h30, 7'h41}));
    run_scroll(3*TD);
    check("wrap back", 32'(hex), 32'({7'h41, 7'h7A, 7'h25, 7'h30}));
    sw[8] = 1'b1;
    m_dir = 1'b1;
    run_scroll(TD);
    check("reverse step", 32'(hex), 32'({7'h30, 7'h41, 7'h7A, 7'h25}));
    run_scroll(2*TD);
    press(1'b1, 1'b0, 3'b011, 2);
    press(1'b0, 1'b1, 3'b000, 0);
    set_en(1'b0);
    check("scroll keys ignored", 32'(ledr[9:4]), 32'd4);

    press(1'b0, 1'b1, 3'b000, 0);
    for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 3'(i % 4), 0);
    check("overflow len", 32'(ledr[9:4]), 32'd8);
    check("overflow hex", 32'(hex), 32'({7'h25, 7'h30, 7'h41, 7'h7A}));

    press(1'b1, 1'b1, 3'b001, 4);
    check("load+clear hex", 32'(hex), 32'h0FFF_FFFF);
    check("load+clear len", 32'(ledr[9:4]), 32'd0);
    set_en(1'b1);
    run_scroll(6);
    check("empty stays edit", 32'(ledr[3]), 32'd0);
    set_en(1'b0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 11);
      repeat (n) press(1'b1, 1'b0, 3'($urandom), $urandom_range(0, 2));
      m_dir = 1'($urandom);
      sw[8] = m_dir;
      set_en(1'b1);
      run_scroll($urandom_range(5, 20));
      set_en(1'b0);
      if ($urandom_range(0, 1) == 1) press(1'b0, 1'b1, 3'b000, 0);
    end

    press(1'b0, 1'b1, 3'b000, 0);
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 3'($urandom_range(0, 3)), 0);
    sw[8] = 1'b0;
    m_dir = 1'b0;
    set_en(1'b1);
    run_scroll(5);
    resetn = 1'b0;
    @(posedge clk);
    q.delete();
    m_scroll = 1'b0;
    @(negedge clk);
    check("midscroll reset hex", 32'(hex), 32'h0FFF_FFFF);
    check("midscroll reset led", 32'(ledr[9:3]), 32'd0);
    check("reset led sw", 32'(ledr[2:0]), 32'(sw[2:0]));
    sw[9] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) cyc();
    check_all("no spurious load");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
